rtc_access_scheduler: RTL

Sequences all traffic to the RTC parallel-bus protocol engine. Arbitrates between user write requests from the time-edit logic and a periodic refresh sweep. Each sweep issues the RAM-transfer command (0xF0), then reads a contiguous block of time registers and streams the results to the VGA register bank. The block sits between the edit/FSM layer and the protocol engine, which owns CS/RD/WR/A-D pin timing.

---
 rtl/rtc_access_scheduler.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/rtc_access_scheduler.sv
// RTC access scheduler: arbitrates buffered user writes against a
// periodic refresh sweep and drives the RTC protocol engine.
module rtc_access_scheduler #(
  parameter int         REFRESH_CYCLES = 1000000,
  parameter logic [7:0] BASE_ADDR      = 8'h21,
  parameter int         NUM_REGS       = 6,
  parameter logic [7:0] CMD_ADDR       = 8'hF0,
  parameter int         TIMEOUT        = 1024
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       wr_req,
  input  logic [7:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic       wr_ack,
  output logic       wr_busy,
  output logic       eng_start,
  output logic       eng_read,
  output logic [7:0] eng_addr,
  output logic [7:0] eng_wdata,
  input  logic       eng_done,
  input  logic [7:0] eng_rdata,
  output logic       rd_valid,
  output logic [7:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       sweep_done,
  output logic       timeout_err,
  input  logic       err_clr,
  output logic       busy
);

  localparam int TW = $clog2(REFRESH_CYCLES) + 1;
  localparam int CW = $clog2(TIMEOUT) + 1;

  localparam logic [TW-1:0] RELOAD = TW'(REFRESH_CYCLES - 1);
  localparam logic [CW-1:0] WLIM   = CW'(TIMEOUT - 2);
  localparam logic [3:0]    LAST   = 4'(NUM_REGS - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_WR_ISSUE  = 3'd1;
  localparam logic [2:0] S_WR_WAIT   = 3'd2;
  localparam logic [2:0] S_CMD_ISSUE = 3'd3;
  localparam logic [2:0] S_CMD_WAIT  = 3'd4;
  localparam logic [2:0] S_RD_ISSUE  = 3'd5;
  localparam logic [2:0] S_RD_WAIT   = 3'd6;

  logic [2:0]    state;
  logic [2:0]    state_n;
  logic          tmo;
  logic          wb_full;
  logic [7:0]    wb_addr;
  logic [7:0]    wb_data;
  logic          sweep_pending;
  logic [TW-1:0] tmr;
  logic [CW-1:0] wait_cnt;
  logic [3:0]    idx;
  logic [3:0]    nxt_idx;
  logic          is_issue;
  logic          in_wait;
  logic          rd_done;
  logic          wb_clr;

  assign is_issue = (state == S_WR_ISSUE) ||
                    (state == S_CMD_ISSUE) ||
                    (state == S_RD_ISSUE);
  assign in_wait  = (state == S_WR_WAIT) ||
                    (state == S_CMD_WAIT) ||
                    (state == S_RD_WAIT);
  assign rd_done  = (state == S_RD_WAIT) && eng_done;
  assign wb_clr   = ((state == S_WR_WAIT) && eng_done) || tmo;
  assign nxt_idx  = (state == S_CMD_WAIT) ? 4'd0 : idx + 4'd1;

  assign eng_start = is_issue;
  assign busy      = (state != S_IDLE);
  assign wr_busy   = wb_full;

  // Next-state logic; a pending write beats a pending sweep in IDLE
  always_comb begin
    state_n = state;
    tmo     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (wb_full)
          state_n = S_WR_ISSUE;
        else if (sweep_pending)
          state_n = S_CMD_ISSUE;
      end
      S_WR_ISSUE:  state_n = S_WR_WAIT;
      S_CMD_ISSUE: state_n = S_CMD_WAIT;
      S_RD_ISSUE:  state_n = S_RD_WAIT;
      S_WR_WAIT, S_CMD_WAIT, S_RD_WAIT: begin
        if (eng_done) begin
          if (state == S_CMD_WAIT)
            state_n = S_RD_ISSUE;
          else if (state == S_RD_WAIT && idx != LAST)
            state_n = S_RD_ISSUE;
          else
            state_n = S_IDLE;
        end else if (wait_cnt == WLIM) begin
          tmo     = 1'b1;
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state <= S_IDLE;
    else
      state <= state_n;
  end

  // Wait counter: cleared while issuing, counts engine wait cycles
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      wait_cnt <= '0;
    else if (is_issue)
      wait_cnt <= '0;
    else if (in_wait)
      wait_cnt <= wait_cnt + 1'b1;
  end

  // Sweep register index
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      idx <= '0;
    else if (state_n == S_RD_ISSUE)
      idx <= nxt_idx;
  end

  // Engine request fields, loaded on entry to an issue state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      eng_read  <= 1'b0;
      eng_addr  <= 8'h00;
      eng_wdata <= 8'h00;
    end else if (state_n != state) begin
      case (state_n)
        S_WR_ISSUE: begin
          eng_read  <= 1'b0;
          eng_addr  <= wb_addr;
          eng_wdata <= wb_data;
        end
        S_CMD_ISSUE: begin
          eng_read  <= 1'b0;
          eng_addr  <= CMD_ADDR;
          eng_wdata <= 8'h00;
        end
        S_RD_ISSUE: begin
          eng_read  <= 1'b1;
          eng_addr  <= BASE_ADDR + {4'h0, nxt_idx};
          eng_wdata <= 8'h00;
        end
        default: ;
      endcase
    end
  end

  // Single-entry write buffer with capture acknowledge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wb_full <= 1'b0;
      wb_addr <= 8'h00;
      wb_data <= 8'h00;
      wr_ack  <= 1'b0;
    end else begin
      wr_ack <= 1'b0;
      if (!wb_full) begin
        if (wr_req) begin
          wb_full <= 1'b1;
          wb_addr <= wr_addr;
          wb_data <= wr_data;
          wr_ack  <= 1'b1;
        end
      end else if (wb_clr) begin
        wb_full <= 1'b0;
      end
    end
  end

  // Refresh timer; a tick in the same cycle as sweep start stays pending
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmr           <= RELOAD;
      sweep_pending <= 1'b1;
    end else begin
      if (state == S_IDLE && state_n == S_CMD_ISSUE)
        sweep_pending <= 1'b0;
      if (tmr == '0) begin
        tmr           <= RELOAD;
        sweep_pending <= 1'b1;
      end else begin
        tmr <= tmr - 1'b1;
      end
    end
  end

  // Read-data return and end-of-sweep pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_valid   <= 1'b0;
      rd_addr    <= 8'h00;
      rd_data    <= 8'h00;
      sweep_done <= 1'b0;
    end else begin
      rd_valid   <= rd_done;
      sweep_done <= rd_done && (idx == LAST);
      if (rd_done) begin
        rd_addr <= eng_addr;
        rd_data <= eng_rdata;
      end
    end
  end

  // Sticky timeout flag; a new timeout beats a clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      timeout_err <= 1'b0;
    else if (tmo)
      timeout_err <= 1'b1;
    else if (err_clr)
      timeout_err <= 1'b0;
  end

endmodule
